// File: rtl/sram_bridge.sv
// Bridge from the arbiter's 32-bit mem_* interface to a 16-bit asynchronous SRAM.
// Writes are posted through a small buffer; reads wait until that buffer drains.

`ifndef MEM_CMD_READ
`define MEM_CMD_READ 1'b0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 1'b1
`endif

module sram_bridge #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18,
    parameter int WBUF_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        mem_addr,
    input  logic [3:0]         mem_mask,
    input  logic               mem_enable,
    input  logic               mem_cmd,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_data,
    output logic               mem_valid,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    output logic               wr_overflow,
    output logic               busy
);

    localparam int              PTR_W    = $clog2(WBUF_DEPTH);
    localparam int              EA_W     = SRAM_AW - 1;
    localparam logic [3:0]      WAIT_LD  = 4'(WAIT_CYCLES);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(WBUF_DEPTH);
    localparam logic [PTR_W:0]  ZERO_CNT = {(PTR_W+1){1'b0}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_r, next_state_s;
    logic [3:0]          wait_r, wait_nxt_s;
    logic [EA_W-1:0]     rd_addr_r, rd_addr_nxt_s;
    logic [15:0]         rd_lo_r;
    logic                after_done_r;
    logic                pop_s, rd_accept_s;

    logic [EA_W-1:0]     wb_addr_r [WBUF_DEPTH];
    logic [31:0]         wb_data_r [WBUF_DEPTH];
    logic [3:0]          wb_mask_r [WBUF_DEPTH];
    logic [PTR_W-1:0]    wptr_r, rptr_r;
    logic [PTR_W:0]      count_r, count_nxt_s;
    logic                push_s, push_ok_s, full_s;
    logic [EA_W-1:0]     head_addr_s;
    logic [31:0]         head_data_s;
    logic [3:0]          head_mask_s;

    logic [31:0]         mem_data_r;
    logic                mem_valid_r, wr_overflow_r, busy_r;
    logic [SRAM_AW-1:0]  sram_addr_r, sram_addr_nxt_s;
    logic [15:0]         dq_out_r, dq_out_nxt_s;
    logic                dq_oe_r, dq_oe_nxt_s;
    logic                ce_n_r, ce_n_nxt_s;
    logic                oe_n_r, oe_n_nxt_s;
    logic                we_n_r, we_n_nxt_s;
    logic                ub_n_r, ub_n_nxt_s;
    logic                lb_n_r, lb_n_nxt_s;

    logic                unused_s;
    assign unused_s = ^{mem_addr[31:SRAM_AW+1], mem_addr[1:0]};

    assign push_s      = mem_enable && (mem_cmd == `MEM_CMD_WRITE);
    assign full_s      = (count_r == FULL_CNT);
    // A full buffer still accepts a push when the head retires in the same cycle.
    assign push_ok_s   = push_s && (!full_s || pop_s);
    assign head_addr_s = wb_addr_r[rptr_r];
    assign head_data_s = wb_data_r[rptr_r];
    assign head_mask_s = wb_mask_r[rptr_r];

    // Posted-write storage; contents are meaningful only between rptr and wptr.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            wb_addr_r[wptr_r] <= mem_addr[SRAM_AW:2];
            wb_data_r[wptr_r] <= mem_wdata;
            wb_mask_r[wptr_r] <= mem_mask;
        end
    end

    // Buffer occupancy for the next cycle.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + 1'b1;
            2'b01:   count_nxt_s = count_r - 1'b1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Buffer pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_r        <= {PTR_W{1'b0}};
            rptr_r        <= {PTR_W{1'b0}};
            count_r       <= ZERO_CNT;
            wr_overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            count_r <= count_nxt_s;
            if (push_s && !push_ok_s) begin
                wr_overflow_r <= 1'b1;
            end
        end
    end

    // Next-state logic; buffered writes always take priority over a pending read.
    always_comb begin
        next_state_s = state_r;
        wait_nxt_s   = wait_r;
        pop_s        = 1'b0;
        rd_accept_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != ZERO_CNT) begin
                    if (head_mask_s[1:0] != 2'b00) begin
                        next_state_s = WR_LO;
                        wait_nxt_s   = WAIT_LD;
                    end else if (head_mask_s[3:2] != 2'b00) begin
                        next_state_s = WR_HI;
                        wait_nxt_s   = WAIT_LD;
                    end else begin
                        pop_s = 1'b1;
                    end
                end else if (mem_enable && (mem_cmd == `MEM_CMD_READ) && !after_done_r) begin
                    next_state_s = RD_LO;
                    wait_nxt_s   = WAIT_LD;
                    rd_accept_s  = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WR_LO: begin
                if (wait_r != 4'd0) begin
                    wait_nxt_s = wait_r - 4'd1;
                end else if (head_mask_s[3:2] != 2'b00) begin
                    next_state_s = WR_HI;
                    wait_nxt_s   = WAIT_LD;
                end else begin
                    pop_s        = 1'b1;
                    next_state_s = IDLE;
                end
            end
            WR_HI: begin
                if (wait_r != 4'd0) begin
                    wait_nxt_s = wait_r - 4'd1;
                end else begin
                    pop_s        = 1'b1;
                    next_state_s = IDLE;
                end
            end
            RD_LO: begin
                if (wait_r != 4'd0) begin
                    wait_nxt_s = wait_r - 4'd1;
                end else begin
                    next_state_s = RD_HI;
                    wait_nxt_s   = WAIT_LD;
                end
            end
            RD_HI: begin
                if (wait_r != 4'd0) begin
                    wait_nxt_s = wait_r - 4'd1;
                end else begin
                    next_state_s = DONE;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    assign rd_addr_nxt_s = rd_accept_s ? mem_addr[SRAM_AW:2] : rd_addr_r;

    // SRAM pin values for the state being entered, so the registered pins line up with it.
    always_comb begin
        sram_addr_nxt_s = {SRAM_AW{1'b0}};
        dq_out_nxt_s    = 16'h0000;
        dq_oe_nxt_s     = 1'b0;
        ce_n_nxt_s      = 1'b1;
        oe_n_nxt_s      = 1'b1;
        we_n_nxt_s      = 1'b1;
        ub_n_nxt_s      = 1'b1;
        lb_n_nxt_s      = 1'b1;
        case (next_state_s)
            WR_LO: begin
                sram_addr_nxt_s = {head_addr_s, 1'b0};
                dq_out_nxt_s    = head_data_s[15:0];
                dq_oe_nxt_s     = 1'b1;
                ce_n_nxt_s      = 1'b0;
                we_n_nxt_s      = 1'b0;
                lb_n_nxt_s      = ~head_mask_s[0];
                ub_n_nxt_s      = ~head_mask_s[1];
            end
            WR_HI: begin
                sram_addr_nxt_s = {head_addr_s, 1'b1};
                dq_out_nxt_s    = head_data_s[31:16];
                dq_oe_nxt_s     = 1'b1;
                ce_n_nxt_s      = 1'b0;
                we_n_nxt_s      = 1'b0;
                lb_n_nxt_s      = ~head_mask_s[2];
                ub_n_nxt_s      = ~head_mask_s[3];
            end
            RD_LO: begin
                sram_addr_nxt_s = {rd_addr_nxt_s, 1'b0};
                ce_n_nxt_s      = 1'b0;
                oe_n_nxt_s      = 1'b0;
                ub_n_nxt_s      = 1'b0;
                lb_n_nxt_s      = 1'b0;
            end
            RD_HI: begin
                sram_addr_nxt_s = {rd_addr_nxt_s, 1'b1};
                ce_n_nxt_s      = 1'b0;
                oe_n_nxt_s      = 1'b0;
                ub_n_nxt_s      = 1'b0;
                lb_n_nxt_s      = 1'b0;
            end
            default: sram_addr_nxt_s = {SRAM_AW{1'b0}};
        endcase
    end

    // State, wait counter, read capture and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            wait_r       <= 4'd0;
            rd_addr_r    <= {EA_W{1'b0}};
            rd_lo_r      <= 16'h0000;
            after_done_r <= 1'b0;
            mem_data_r   <= 32'h0000_0000;
            mem_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            sram_addr_r  <= {SRAM_AW{1'b0}};
            dq_out_r     <= 16'h0000;
            dq_oe_r      <= 1'b0;
            ce_n_r       <= 1'b1;
            oe_n_r       <= 1'b1;
            we_n_r       <= 1'b1;
            ub_n_r       <= 1'b1;
            lb_n_r       <= 1'b1;
        end else begin
            state_r      <= next_state_s;
            wait_r       <= wait_nxt_s;
            rd_addr_r    <= rd_addr_nxt_s;
            after_done_r <= (state_r == DONE);
            if ((state_r == RD_LO) && (wait_r == 4'd0)) begin
                rd_lo_r <= sram_dq_in;
            end
            if ((state_r == RD_HI) && (wait_r == 4'd0)) begin
                mem_data_r <= {sram_dq_in, rd_lo_r};
            end
            mem_valid_r  <= (next_state_s == DONE);
            busy_r       <= (next_state_s != IDLE) || (count_nxt_s != ZERO_CNT);
            sram_addr_r  <= sram_addr_nxt_s;
            dq_out_r     <= dq_out_nxt_s;
            dq_oe_r      <= dq_oe_nxt_s;
            ce_n_r       <= ce_n_nxt_s;
            oe_n_r       <= oe_n_nxt_s;
            we_n_r       <= we_n_nxt_s;
            ub_n_r       <= ub_n_nxt_s;
            lb_n_r       <= lb_n_nxt_s;
        end
    end

    assign mem_data    = mem_data_r;
    assign mem_valid   = mem_valid_r;
    assign wr_overflow = wr_overflow_r;
    assign busy        = busy_r;
    assign sram_addr   = sram_addr_r;
    assign sram_dq_out = dq_out_r;
    assign sram_dq_oe  = dq_oe_r;
    assign sram_ce_n   = ce_n_r;
    assign sram_oe_n   = oe_n_r;
    assign sram_we_n   = we_n_r;
    assign sram_ub_n   = ub_n_r;
    assign sram_lb_n   = lb_n_r;

endmodule
